// File: rtl/gcd_requester.sv
// Initiator for the GCD engine start/done interface: one operand pair in flight, zero operands bypass the engine.
// Build option: define GCD_TIMEOUT_EN to abort a stuck engine after TIMEOUT wait cycles.
//
// state   | meaning
// IDLE    | ready for an operand pair
// ISSUE   | eng_start pulse, operands stable on eng_a/eng_b
// WAIT    | waiting for eng_done (optionally bounded by TIMEOUT)
// HOLD    | result presented downstream until out_ready
module gcd_requester #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err,
  output logic [15:0]      done_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;
  state_t state;

  generate
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("gcd_requester: TIMEOUT must be at least 1");
    end
  endgenerate

`ifdef GCD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter holds the number of completed WAIT cycles; abort on the TIMEOUT-th one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      eng_start <= 1'b0;
      eng_a     <= '0;
      eng_b     <= '0;
      out_valid <= 1'b0;
      out_gcd   <= '0;
      out_a     <= '0;
      out_b     <= '0;
      done_cnt  <= '0;
`ifdef GCD_TIMEOUT_EN
      out_err   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      eng_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            eng_a    <= in_a;
            eng_b    <= in_b;
            out_a    <= in_a;
            out_b    <= in_b;
            in_ready <= 1'b0;
            if (in_a == '0 || in_b == '0) begin
              out_gcd   <= in_a | in_b;
              out_valid <= 1'b1;
`ifdef GCD_TIMEOUT_EN
              out_err   <= 1'b0;
`endif
              state     <= S_HOLD;
            end else begin
              eng_start <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
`ifdef GCD_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done coinciding with the timeout limit still delivers the real result.
          if (eng_done) begin
            out_gcd   <= eng_result;
            out_valid <= 1'b1;
`ifdef GCD_TIMEOUT_EN
            out_err   <= 1'b0;
`endif
            state     <= S_HOLD;
          end
`ifdef GCD_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            out_gcd   <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            done_cnt  <= done_cnt + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a small behavioural GCD engine attached.
// Covers engine path, zero bypass, back-pressure, mid-operation reset and the timeout option.
module tb_gcd_requester;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             eng_start;
  logic [WIDTH-1:0] eng_a, eng_b;
  logic             eng_done;
  logic [WIDTH-1:0] eng_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd, out_a, out_b;
  logic             out_err;
  logic [15:0]      done_cnt;

  int checks = 0;
  int errors = 0;

  // engine model controls
  int   eng_delay = 3;
  logic eng_never = 1'b0;
  logic inj_done  = 1'b0;
  int   start_cnt = 0;
  logic e_busy;
  int   e_cnt;

  always #5 clk = ~clk;

  gcd_requester #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gcd(out_gcd), .out_a(out_a), .out_b(out_b),
    .out_err(out_err), .done_cnt(done_cnt)
  );

  function automatic logic [WIDTH-1:0] gcd_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_done   <= 1'b0;
      eng_result <= '0;
      e_busy     <= 1'b0;
      e_cnt      <= 0;
    end else begin
      eng_done <= 1'b0;
      if (eng_start) start_cnt <= start_cnt + 1;
      if (inj_done) begin
        eng_done   <= 1'b1;
        eng_result <= 16'hBEEF;
      end else if (eng_start && !eng_never) begin
        e_busy <= 1'b1;
        e_cnt  <= eng_delay;
      end else if (e_busy) begin
        if (e_cnt == 0) begin
          eng_done   <= 1'b1;
          eng_result <= gcd_f(eng_a, eng_b);
          e_busy     <= 1'b0;
        end else begin
          e_cnt <= e_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge with in_ready expected high; returns at the negedge after acceptance.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    chk("in_ready_before_send", in_ready, 1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n, output logic done_before, output logic rdy_low);
    n = 0;
    done_before = 1'b0;
    rdy_low = 1'b1;
    while (out_valid !== 1'b1 && n < max) begin
      done_before = eng_done;
      if (in_ready !== 1'b0) rdy_low = 1'b0;
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b0) rdy_low = 1'b0;
    chk("out_valid_within_bound", (n < max), 1);
  endtask

  int   n;
  logic dprev, rlow;
  int   starts0;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_out_gcd", out_gcd, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // (20,30) through the engine
    send(16'd20, 16'd30);
    chk("t1_in_ready_low", in_ready, 0);
    chk("t1_eng_start", eng_start, 1);
    chk("t1_eng_a", eng_a, 20);
    chk("t1_eng_b", eng_b, 30);
    wait_valid(100, n, dprev, rlow);
    chk("t1_valid_after_done", dprev, 1);
    chk("t1_out_gcd", out_gcd, 10);
    chk("t1_out_a", out_a, 20);
    chk("t1_out_b", out_b, 30);
    chk("t1_out_err", out_err, 0);
    @(negedge clk);
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_in_ready_back", in_ready, 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_start_pulses", start_cnt, 1);

    // (10,2) back-to-back
    send(16'd10, 16'd2);
    wait_valid(100, n, dprev, rlow);
    chk("t2_in_ready_low_until_hs", rlow, 1);
    chk("t2_out_gcd", out_gcd, 2);
    @(negedge clk);
    chk("t2_done_cnt", done_cnt, 2);
    chk("t2_start_pulses", start_cnt, 2);

    // zero bypass
    send(16'd0, 16'd7);
    chk("t3_valid_1cyc", out_valid, 1);
    chk("t3_no_start", eng_start, 0);
    chk("t3_out_gcd", out_gcd, 7);
    chk("t3_out_a", out_a, 0);
    @(negedge clk);
    chk("t3_done_cnt", done_cnt, 3);
    send(16'd0, 16'd0);
    chk("t4_valid_1cyc", out_valid, 1);
    chk("t4_out_gcd", out_gcd, 0);
    @(negedge clk);
    chk("t4_done_cnt", done_cnt, 4);
    chk("t4_start_pulses", start_cnt, 2);

    // back-pressure
    out_ready = 1'b0;
    send(16'd48, 16'd18);
    wait_valid(100, n, dprev, rlow);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_gcd", out_gcd, 6);
      @(negedge clk);
    end
    chk("t5_done_cnt_stalled", done_cnt, 4);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_valid_drop", out_valid, 0);
    chk("t5_done_cnt", done_cnt, 5);
    @(negedge clk);
    chk("t5_done_cnt_once", done_cnt, 5);

`ifdef GCD_TIMEOUT_EN
    // engine never answers
    eng_never = 1'b1;
    out_ready = 1'b0;
    send(16'd5, 16'd15);
    chk("t6_eng_start", eng_start, 1);
    wait_valid(200, n, dprev, rlow);
    chk("t6_timeout_latency", n, TIMEOUT + 1);
    chk("t6_out_err", out_err, 1);
    chk("t6_out_gcd", out_gcd, 0);
    chk("t6_out_a", out_a, 5);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    chk("t6_late_done_gcd", out_gcd, 0);
    chk("t6_late_done_err", out_err, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_done_cnt", done_cnt, 6);
    eng_never = 1'b0;
`else
    // a slow engine is simply waited for
    eng_delay = 100;
    send(16'd12, 16'd8);
    wait_valid(300, n, dprev, rlow);
    chk("t6_slow_valid_after_done", dprev, 1);
    chk("t6_slow_gcd", out_gcd, 4);
    chk("t6_slow_err", out_err, 0);
    @(negedge clk);
    chk("t6_done_cnt", done_cnt, 6);
`endif

    // reset during WAIT
    eng_delay = 20;
    starts0 = start_cnt;
    send(16'd20, 16'd30);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t7_rst_in_ready", in_ready, 1);
    chk("t7_rst_out_valid", out_valid, 0);
    chk("t7_rst_eng_a", eng_a, 0);
    chk("t7_rst_out_a", out_a, 0);
    chk("t7_rst_out_gcd", out_gcd, 0);
    chk("t7_rst_done_cnt", done_cnt, 0);
    chk("t7_rst_start_pulse", start_cnt, starts0 + 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    eng_delay = 2;
    send(16'd9, 16'd6);
    wait_valid(100, n, dprev, rlow);
    chk("t7_out_gcd", out_gcd, 3);
    chk("t7_out_err", out_err, 0);
    @(negedge clk);
    chk("t7_done_cnt", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
